// File: rtl/pc_speaker_pkg.sv
// Shared types and constants for the PC speaker audio path: sample/filter widths
// and the per-cycle duty contribution rule.
package pc_speaker_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int FILT_W          = 18;
  localparam int FULL_SCALE      = 16384;
  localparam int FULL_SCALE_LOG2 = 14;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [FILT_W-1:0]   filt_t;

  // Speaker gated off contributes nothing; otherwise the PIT level maps to +1/-1.
  function automatic logic signed [1:0] contribution(input logic spk, input logic pit);
    if (!spk)     return 2'sd0;
    else if (pit) return 2'sd1;
    else          return -2'sd1;
  endfunction

endpackage

// File: rtl/pc_speaker_iir.sv
// First-order IIR low-pass: y += (x - y) >>> FILT_SHIFT on each load strobe.
// FILT_SHIFT = 0 makes the filter transparent (y_next = x).
module pc_speaker_iir
  import pc_speaker_pkg::*;
#(
  parameter int FILT_SHIFT = 2
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  clear,
  input  logic  load,
  input  filt_t x,
  output filt_t y_next,
  output filt_t y
);

  filt_t diff;

  // |x|,|y| <= 16384, so the difference and the sum both fit in 18 bits.
  assign diff   = x - y;
  assign y_next = y + (diff >>> FILT_SHIFT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     y <= '0;
    else if (clear) y <= '0;
    else if (load)  y <= y_next;
  end

endmodule

// File: rtl/pc_speaker_audio.sv
// PC speaker PCM source: synchronizes the PIT output, integrates signed duty over a
// 2**DECIM_LOG2 window, low-pass filters it and offers samples over valid/ready.
module pc_speaker_audio
  import pc_speaker_pkg::*;
#(
  parameter int DECIM_LOG2 = 10,
  parameter int FILT_SHIFT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        pit_out,
  input  logic        spk_data,
  output logic [15:0] audio_sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  input  logic        overrun_clr
);

  localparam int ACC_W   = DECIM_LOG2 + 2;
  localparam int X_SHIFT = FULL_SCALE_LOG2 - DECIM_LOG2;

  logic                    pit_m;
  logic                    pit_s;
  logic [DECIM_LOG2-1:0]   wcnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] d_ext;
  logic signed [ACC_W-1:0] c;
  logic signed [1:0]       d;
  logic                    win_last;
  logic                    load;
  filt_t                   c_ext;
  filt_t                   x;
  filt_t                   y_next;
  filt_t                   y;

  // NOTE: two plain flops on the asynchronous PIT line; only pit_s is used downstream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pit_m <= 1'b0;
      pit_s <= 1'b0;
    end else begin
      pit_m <= pit_out;
      pit_s <= pit_m;
    end
  end

  assign d        = contribution(spk_data, pit_s);
  assign d_ext    = {{(ACC_W-2){d[1]}}, d};
  assign c        = acc + d_ext;
  assign win_last = (wcnt == '1);
  assign load     = enable && win_last;

  // Scale the window sum so a fully-high window lands exactly on FULL_SCALE.
  assign c_ext = {{(FILT_W-ACC_W){c[ACC_W-1]}}, c};
  assign x     = c_ext <<< X_SHIFT;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
      acc  <= '0;
    end else if (!enable) begin
      wcnt <= '0;
      acc  <= '0;
    end else if (win_last) begin
      wcnt <= '0;
      acc  <= '0;
    end else begin
      wcnt <= wcnt + 1'b1;
      acc  <= c;
    end
  end

  pc_speaker_iir #(
    .FILT_SHIFT (FILT_SHIFT)
  ) u_iir (
    .clock  (clock),
    .reset  (reset),
    .clear  (!enable),
    .load   (load),
    .x      (x),
    .y_next (y_next),
    .y      (y)
  );

  // A new sample always wins the output register; an unread one is lost and flagged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      audio_sample <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (load) begin
        audio_sample <= y_next[SAMPLE_W-1:0];
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      if (load && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (overrun_clr)                      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_speaker_audio.sv
// Scoreboard bench for pc_speaker_audio: two instances (FILT_SHIFT 0 and 2) share
// stimulus; a window-level model predicts samples, valid and overrun.
module tb_pc_speaker_audio;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        pit_out;
  logic        spk_data;
  logic        sample_ready;
  logic        overrun_clr;
  logic [15:0] s0, s2;
  logic        v0, v2, o0, o2;

  always #5 clock = ~clock;

  pc_speaker_audio #(.DECIM_LOG2(4), .FILT_SHIFT(0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .pit_out(pit_out), .spk_data(spk_data),
    .audio_sample(s0), .sample_valid(v0), .sample_ready(sample_ready),
    .overrun(o0), .overrun_clr(overrun_clr)
  );

  pc_speaker_audio #(.DECIM_LOG2(4), .FILT_SHIFT(2)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .pit_out(pit_out), .spk_data(spk_data),
    .audio_sample(s2), .sample_valid(v2), .sample_ready(sample_ready),
    .overrun(o2), .overrun_clr(overrun_clr)
  );

  typedef struct { int v0; int v2; } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   got0[$];
  int   got2[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: window of contributions, filter outputs, handshake flags.
  bit   pit_q[$];
  int   win[$];
  int   y_m[2];
  bit   m_valid;
  bit   m_overrun;
  int   m_windows = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid   = 1'b0;
      m_overrun = 1'b0;
      y_m       = '{0, 0};
      win.delete();
      expq.delete();
      pit_q     = '{1'b0, 1'b0};
    end else begin : model
      bit ps;
      bit new_s;
      int d;
      int c;
      ps    = pit_q.pop_front();
      pit_q.push_back(pit_out);
      d     = !spk_data ? 0 : (ps ? 1 : -1);
      new_s = 1'b0;
      if (!enable) begin
        win.delete();
        y_m = '{0, 0};
      end else begin
        win.push_back(d);
        if (win.size() == 16) begin
          c = 0;
          foreach (win[i]) c += win[i];
          y_m[0] = y_m[0] + ((c * 1024 - y_m[0]) >>> 0);
          y_m[1] = y_m[1] + ((c * 1024 - y_m[1]) >>> 2);
          win.delete();
          new_s = 1'b1;
          m_windows++;
        end
      end
      if (new_s && m_valid && !sample_ready) begin
        m_overrun = 1'b1;
        void'(expq.pop_front());
      end else if (overrun_clr) begin
        m_overrun = 1'b0;
      end
      if (new_s) begin
        expq.push_back(exp_t'{y_m[0], y_m[1]});
        m_valid = 1'b1;
      end else if (m_valid && sample_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: compare handshake flags every cycle, pop and compare on each transfer.
  always @(negedge clock) begin
    if (!reset) begin
      check("valid0", v0, m_valid);
      check("valid2", v2, m_valid);
      check("overrun0", o0, m_overrun);
      check("overrun2", o2, m_overrun);
      if (m_valid && sample_ready) begin
        check("sb_depth", expq.size(), 1);
        if (expq.size() > 0) begin
          mon_e = expq.pop_front();
          check("sample0", $signed(s0), mon_e.v0);
          check("sample2", $signed(s2), mon_e.v2);
          got0.push_back(int'($signed(s0)));
          got2.push_back(int'($signed(s2)));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_got(input int n, input int budget);
    int k = 0;
    while (got0.size() < n && k < budget) begin
      @(posedge clock);
      k++;
    end
    #1;
    check("wait_samples", got0.size(), n);
  endtask

  task automatic wait_window();
    int start = m_windows;
    int k = 0;
    while (m_windows == start && k < 100) begin
      @(posedge clock);
      k++;
    end
    #1;
    check("window_seen", m_windows, start + 1);
  endtask

  initial begin
    int k;
    int seen;
    reset        = 1'b1;
    enable       = 1'b1;
    pit_out      = 1'b0;
    spk_data     = 1'b0;
    sample_ready = 1'b1;
    overrun_clr  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_sample", $signed(s0), 0);
    check("rst_valid", v0, 0);
    check("rst_overrun", o2, 0);

    // Release with full-scale input: first window loses two cycles to the synchronizer.
    spk_data = 1'b1;
    pit_out  = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    got0.delete();
    got2.delete();
    wait_got(2, 80);
    check("t2_first", got0[0], 12288);
    check("t2_steady", got0[1], 16384);

    // Speaker gated off: PIT activity must not reach the output.
    spk_data = 1'b0;
    for (int i = 0; i < 96; i++) begin
      if (i % 3 == 0) pit_out = ~pit_out;
      cycles(1);
    end
    check("t1_zero", got0[got0.size()-1], 0);

    // Balanced square wave, then constant low.
    spk_data = 1'b1;
    for (int i = 0; i < 96; i++) begin
      pit_out = (i % 4) < 2;
      cycles(1);
    end
    check("t3_square", got0[got0.size()-1], 0);
    pit_out = 1'b0;
    cycles(64);
    check("t3_low", got0[got0.size()-1], -16384);

    // Step response of the FILT_SHIFT=2 instance from a cleared filter.
    enable  = 1'b0;
    pit_out = 1'b1;
    cycles(4);
    got0.delete();
    got2.delete();
    enable = 1'b1;
    wait_got(4, 100);
    check("t4_s1", got2[0], 4096);
    check("t4_s2", got2[1], 7168);
    check("t4_s3", got2[2], 9472);
    check("t4_s4", got2[3], 11200);

    // Stall across two windows, then drain and clear the sticky flag.
    sample_ready = 1'b0;
    cycles(40);
    check("t5_overrun", o0, 1);
    check("t5_latest", $signed(s0), 16384);
    wait_window();
    cycles(2);
    sample_ready = 1'b1;
    cycles(1);
    sample_ready = 1'b0;
    @(negedge clock);
    check("t5_drained", v0, 0);
    @(posedge clock);
    #1 overrun_clr = 1'b1;
    cycles(1);
    overrun_clr = 1'b0;
    @(negedge clock);
    check("t5_cleared", o0, 0);

    // Reset in the middle of a window while a sample is pending.
    wait_window();
    cycles(6);
    reset = 1'b1;
    #1;
    check("t6_sample", $signed(s0), 0);
    check("t6_valid", v0, 0);
    check("t6_overrun", o2, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    sample_ready = 1'b1;
    k = 0;
    while (!v0 && k < 100) begin
      @(posedge clock);
      k++;
      #1;
    end
    check("t6_latency", k, 16);

    // Enable dropped mid-window: no sample may appear while disabled.
    wait_window();
    cycles(5);
    enable = 1'b0;
    seen   = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (v0) seen++;
    end
    check("t7_no_sample", seen, 0);
    @(posedge clock);
    #1 enable = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 900; i++) begin
      spk_data     = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) pit_out = ~pit_out;
      sample_ready = ($urandom_range(0, 3) != 0);
      overrun_clr  = ($urandom_range(0, 9) == 0);
      enable       = ($urandom_range(0, 59) != 0);
      cycles(1);
    end
    enable       = 1'b1;
    sample_ready = 1'b1;
    overrun_clr  = 1'b0;
    cycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
